// File: rtl/mcu_component_scheduler.sv
// Arbitrates one shared block pipeline between the Y, Cb and Cr MCU FIFOs, emitting whole
// blocks in JPEG interleave order on a registered valid/ready port tagged with the component.
module mcu_component_scheduler #(
  parameter int unsigned MCU_SIZE  = 8,
  parameter int unsigned BIT_WIDTH = 8,
  parameter int unsigned Y_PER_MCU = 4
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  y_empty,
  output logic                                  y_re,
  input  logic                                  y_valid,
  input  logic                                  y_last,
  input  logic [MCU_SIZE*MCU_SIZE*BIT_WIDTH-1:0] y_data,
  input  logic                                  cb_empty,
  output logic                                  cb_re,
  input  logic                                  cb_valid,
  input  logic                                  cb_last,
  input  logic [MCU_SIZE*MCU_SIZE*BIT_WIDTH-1:0] cb_data,
  input  logic                                  cr_empty,
  output logic                                  cr_re,
  input  logic                                  cr_valid,
  input  logic                                  cr_last,
  input  logic [MCU_SIZE*MCU_SIZE*BIT_WIDTH-1:0] cr_data,
  output logic [MCU_SIZE*MCU_SIZE*BIT_WIDTH-1:0] blk_data,
  output logic [1:0]                            blk_comp,
  output logic                                  blk_last,
  output logic                                  blk_valid,
  input  logic                                  blk_ready,
  output logic [15:0]                           mcu_cnt,
  output logic                                  busy
);

  localparam int unsigned DataW = MCU_SIZE * MCU_SIZE * BIT_WIDTH;
  localparam logic [1:0] CompY  = 2'd0;
  localparam logic [1:0] CompCb = 2'd1;
  localparam logic [1:0] CompCr = 2'd2;
  localparam logic [1:0] YMax   = 2'(Y_PER_MCU - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StPresent} state_e;

  state_e             state_q, state_d;
  logic [1:0]         comp_q, comp_d;
  logic [1:0]         ycnt_q, ycnt_d;
  logic [15:0]        mcu_cnt_q, mcu_cnt_d;
  logic [DataW-1:0]   blk_data_q, blk_data_d;
  logic [1:0]         blk_comp_q, blk_comp_d;
  logic               blk_last_q, blk_last_d;
  logic               blk_valid_q, blk_valid_d;

  logic               sel_empty, sel_valid, sel_last, issue;
  logic [DataW-1:0]   sel_data;

  always_comb begin
    sel_empty = y_empty;
    sel_valid = y_valid;
    sel_last  = y_last;
    sel_data  = y_data;
    unique case (comp_q)
      CompCb: begin
        sel_empty = cb_empty;
        sel_valid = cb_valid;
        sel_last  = cb_last;
        sel_data  = cb_data;
      end
      CompCr: begin
        sel_empty = cr_empty;
        sel_valid = cr_valid;
        sel_last  = cr_last;
        sel_data  = cr_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    comp_d      = comp_q;
    ycnt_d      = ycnt_q;
    mcu_cnt_d   = mcu_cnt_q;
    blk_data_d  = blk_data_q;
    blk_comp_d  = blk_comp_q;
    blk_last_d  = blk_last_q;
    blk_valid_d = blk_valid_q;
    issue       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!y_empty) begin
          state_d = StIssue;
          comp_d  = CompY;
          ycnt_d  = 2'd0;
        end
      end
      StIssue: begin
        if (!sel_empty) begin
          issue   = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        // Only the FIFO just read can be valid here; others are ignored.
        if (sel_valid) begin
          blk_data_d  = sel_data;
          blk_comp_d  = comp_q;
          blk_last_d  = sel_last && (comp_q == CompCr);
          blk_valid_d = 1'b1;
          state_d     = StPresent;
        end
      end
      StPresent: begin
        if (blk_valid_q && blk_ready) begin
          blk_valid_d = 1'b0;
          state_d     = StIssue;
          if (comp_q == CompY) begin
            if (ycnt_q < YMax) begin
              ycnt_d = ycnt_q + 2'd1;
            end else begin
              ycnt_d = 2'd0;
              comp_d = CompCb;
            end
          end else if (comp_q == CompCb) begin
            comp_d = CompCr;
          end else begin
            comp_d = CompY;
            ycnt_d = 2'd0;
            if (blk_last_q) begin
              mcu_cnt_d = 16'd0;
              state_d   = StIdle;
            end else begin
              mcu_cnt_d = mcu_cnt_q + 16'd1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= StIdle;
      comp_q      <= CompY;
      ycnt_q      <= 2'd0;
      mcu_cnt_q   <= 16'd0;
      blk_data_q  <= '0;
      blk_comp_q  <= CompY;
      blk_last_q  <= 1'b0;
      blk_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      comp_q      <= comp_d;
      ycnt_q      <= ycnt_d;
      mcu_cnt_q   <= mcu_cnt_d;
      blk_data_q  <= blk_data_d;
      blk_comp_q  <= blk_comp_d;
      blk_last_q  <= blk_last_d;
      blk_valid_q <= blk_valid_d;
    end
  end

  assign y_re      = issue && (comp_q == CompY);
  assign cb_re     = issue && (comp_q == CompCb);
  assign cr_re     = issue && (comp_q == CompCr);
  assign blk_data  = blk_data_q;
  assign blk_comp  = blk_comp_q;
  assign blk_last  = blk_last_q;
  assign blk_valid = blk_valid_q;
  assign mcu_cnt   = mcu_cnt_q;
  assign busy      = (state_q != StIdle);

endmodule
